// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting unit and the bit-serial adder controller.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C;

  modport master (output start, A, B, input busy, done, Sum, C);
  modport slave  (input start, A, B, output busy, done, Sum, C);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first, start/busy/done handshake.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on the accepting edge
// RUN     | one bit per edge for WIDTH edges; result/carry published on the last
// DONE    | one-cycle done pulse, start ignored
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             bit_s;
  logic             bit_cy;
  logic [WIDTH-1:0] res_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_d     = c_q;
    cnt_d   = cnt_q;

    // shared 1-bit adder cell
    bit_s  = a_q[0] ^ b_q[0] ^ carry_q;
    bit_cy = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    res_sh = res_q >> 1;
    res_sh[WIDTH-1] = bit_s;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_sh;
        carry_d = bit_cy;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_sh;
          c_d     = bit_cy;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.Sum  = sum_q;
  assign bus.C    = c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 against a cycle-level behavioural model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(1)) if1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int n_cmp = 0;
  int n_err = 0;

  // model: index 0 is the 8-bit instance, index 1 the 1-bit instance
  int       rem   [2];
  int       pend  [2];
  int       m_out [2];
  int       wid   [2];

  initial begin
    wid[0] = 8;
    wid[1] = 1;
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; pend[i] = 0; m_out[i] = 0;
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; pend[i] = 0; m_out[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic st;
        int   av, bv;
        st = (i == 0) ? if8.start : if1.start;
        av = (i == 0) ? int'(if8.A) : int'(if1.A);
        bv = (i == 0) ? int'(if8.B) : int'(if1.B);
        if (rem[i] == 0) begin
          if (st) begin
            rem[i]  = wid[i] + 1;
            pend[i] = av + bv;
          end
        end else begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 1) m_out[i] = pend[i];
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy8", int'(if8.busy), (rem[0] > 0) ? 1 : 0);
    chk("done8", int'(if8.done), (rem[0] == 1) ? 1 : 0);
    chk("res8",  int'({if8.C, if8.Sum}), m_out[0]);
    chk("busy1", int'(if1.busy), (rem[1] > 0) ? 1 : 0);
    chk("done1", int'(if1.done), (rem[1] == 1) ? 1 : 0);
    chk("res1",  int'({if1.C, if1.Sum}), m_out[1]);
  end

  // returns negedges from accept to done (0 if it never came)
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic scramble,
                      output int lat);
    lat = 0;
    @(negedge clk);
    if8.A = a; if8.B = b; if8.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if8.start = 1'b0;
        if (scramble) begin
          if8.A = 8'($urandom); if8.B = 8'($urandom);
        end
      end
      if (if8.done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("timeout8", 0, 1);
  endtask

  task automatic add1(input logic a, input logic b, output int lat);
    lat = 0;
    @(negedge clk);
    if1.A = a; if1.B = b; if1.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) if1.start = 1'b0;
      if (if1.done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("timeout1", 0, 1);
  endtask

  initial begin
    int lat;
    int ndone;
    logic prev_done;
    if8.start = 1'b0; if8.A = '0; if8.B = '0;
    if1.start = 1'b0; if1.A = '0; if1.B = '0;

    // 1: reset held with random inputs
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if8.start = 1'($urandom); if8.A = 8'($urandom); if8.B = 8'($urandom);
      if1.start = 1'($urandom); if1.A = 1'($urandom); if1.B = 1'($urandom);
      chk("rst_busy", int'(if8.busy), 0);
      chk("rst_sum",  int'({if8.C, if8.Sum}), 0);
    end
    @(negedge clk);
    if8.start = 1'b0; if1.start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2: 0xFF + 0x01
    add8(8'hFF, 8'h01, 1'b0, lat);
    chk("t2_lat", lat, 9);
    chk("t2_sum", int'(if8.Sum), 8'h00);
    chk("t2_c",   int'(if8.C), 1);
    @(negedge clk);
    chk("t2_busy_after", int'(if8.busy), 0);

    // 3: operands changed after accept
    add8(8'hA5, 8'h5A, 1'b1, lat);
    chk("t3_sum", int'(if8.Sum), 8'hFF);
    chk("t3_c",   int'(if8.C), 0);
    repeat (2) @(negedge clk);

    // 4: start held high for four back-to-back adds
    ndone = 0;
    prev_done = 1'b0;
    if8.A = 8'h7F; if8.B = 8'h01; if8.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if8.done) begin
        ndone++;
        chk("t4_sum", int'({if8.C, if8.Sum}), 9'h080);
        if (prev_done) chk("t4_b2b", 1, 0);
      end
      prev_done = if8.done;
    end
    if8.start = 1'b0;
    chk("t4_count", ndone, 4);
    repeat (12) @(negedge clk);

    // 5: reset in the middle of an add
    @(negedge clk);
    if8.A = 8'h3C; if8.B = 8'h0F; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(if8.busy), 0);
    chk("t5_sum",  int'({if8.C, if8.Sum}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if8.done) ndone++;
    end
    chk("t5_no_done", ndone, 0);
    add8(8'h01, 8'h02, 1'b0, lat);
    chk("t5_sum2", int'({if8.C, if8.Sum}), 9'h003);
    repeat (2) @(negedge clk);

    // 6: WIDTH=1 exhaustive
    for (int p = 0; p < 4; p++) begin
      logic [1:0] ab;
      ab = 2'(p);
      add1(ab[1], ab[0], lat);
      chk("t6_lat", lat, 2);
      chk("t6_res", int'({if1.C, if1.Sum}), int'(ab[1]) + int'(ab[0]));
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
